// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status/instruction codes and pipeline bubble values
package y86_pkg;
  localparam logic [3:0] S_AOK = 4'h1, S_HLT = 4'h2, S_ADR = 4'h3, S_INS = 4'h4;
  localparam logic [3:0] I_NOP = 4'h1, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_CALL = 4'h8;
  localparam logic [3:0] I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  localparam logic [3:0] RNONE = 4'hF;
  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;
  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;
  localparam m_reg_t M_BUBBLE = '{S_AOK, I_NOP, 1'b0, 64'h0, 64'h0, RNONE, RNONE};
  localparam w_reg_t W_BUBBLE = '{S_AOK, I_NOP, 64'h0, 64'h0, RNONE, RNONE};
endpackage

// File: rtl/y86_data_mem.sv
// y86_data_mem: byte-addressed little-endian 8-byte data memory with address check (Y86_ALIGN_CHECK_EN adds alignment)
module y86_data_mem #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        valid
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);
  logic [7:0] mem [MEM_BYTES];
  logic [AW-1:0] base;
  assign base = addr[AW-1:0];
`ifdef Y86_ALIGN_CHECK_EN
  assign valid = addr <= LAST && addr[2:0] == 3'd0;
`else
  assign valid = addr <= LAST;
`endif
  always_comb begin
    rdata = '0;
    for (int b = 0; b < 8; b++) rdata[8*b +: 8] = valid ? mem[base + AW'(b)] : 8'h00;
  end
  always_ff @(posedge clk)
    if (we) for (int b = 0; b < 8; b++) mem[base + AW'(b)] <= wdata[8*b +: 8];
endmodule

// File: rtl/y86_memory_stage.sv
// y86_memory_stage: Y86-64 memory stage with M/W pipeline registers and data memory; Y86_ALIGN_CHECK_EN rejects unaligned accesses
module y86_memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_bubble,
  input  logic        W_stall,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);
  m_reg_t r_m;
  w_reg_t r_w;
  logic w_rd, w_wr, w_valid, w_we;
  logic [63:0] w_addr, w_rdata;
  assign w_rd = r_m.icode inside {I_MRMOVQ, I_POPQ, I_RET};
  assign w_wr = r_m.icode inside {I_RMMOVQ, I_PUSHQ, I_CALL};
  assign w_addr = (r_m.icode == I_POPQ || r_m.icode == I_RET) ? r_m.val_a : r_m.val_e;
  assign m_stat = (w_rd || w_wr) && !w_valid ? S_ADR : r_m.stat;
  assign m_valM = w_rd ? w_rdata : 64'h0;
  assign w_we = w_wr && w_valid && m_stat == S_AOK && r_w.stat == S_AOK && !rst;
  y86_data_mem #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .clk(clk),
    .we(w_we),
    .addr(w_addr),
    .wdata(r_m.val_a),
    .rdata(w_rdata),
    .valid(w_valid)
  );
  always_ff @(posedge clk) begin
    r_m <= (rst || M_bubble) ? M_BUBBLE : '{e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM};
    if (rst) r_w <= W_BUBBLE;
    else if (!W_stall) r_w <= '{m_stat, r_m.icode, r_m.val_e, m_valM, r_m.dst_e, r_m.dst_m};
  end
  assign M_stat = r_m.stat;
  assign M_icode = r_m.icode;
  assign M_cnd = r_m.cnd;
  assign M_valE = r_m.val_e;
  assign M_valA = r_m.val_a;
  assign M_dstE = r_m.dst_e;
  assign M_dstM = r_m.dst_m;
  assign W_stat = r_w.stat;
  assign W_icode = r_w.icode;
  assign W_valE = r_w.val_e;
  assign W_valM = r_w.val_m;
  assign W_dstE = r_w.dst_e;
  assign W_dstM = r_w.dst_m;
endmodule

// File: tb/tb_y86_memory_stage.sv
// tb_y86_memory_stage: randomized self-checking bench against a behavioural memory-stage model
module tb_y86_memory_stage;
  localparam int MB = 1024;
  logic clk = 0, rst = 1, M_bubble = 0, W_stall = 0;
  logic [3:0] e_stat = 1, e_icode = 1, e_dstE = 15, e_dstM = 15;
  logic e_cnd = 0;
  logic [63:0] e_valE = 0, e_valA = 0;
  logic [3:0] M_stat, M_icode, M_dstE, M_dstM, m_stat, W_stat, W_icode, W_dstE, W_dstM;
  logic M_cnd;
  logic [63:0] M_valE, M_valA, m_valM, W_valE, W_valM;
  int total = 0, bad = 0;
  logic [3:0] ms = 1, mi = 1, mde = 15, mdm = 15, ws = 1, wi = 1, wde = 15, wdm = 15;
  logic mc = 0;
  logic [63:0] mve = 0, mva = 0, wve = 0, wvm = 0;
  logic [7:0] mem [MB];
  always #5 clk = ~clk;
  y86_memory_stage #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .M_bubble(M_bubble), .W_stall(W_stall),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd), .e_valE(e_valE), .e_valA(e_valA),
    .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .m_valM(m_valM), .m_stat(m_stat),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );
  function automatic bit ok_addr(logic [63:0] a);
    bit r;
    r = (a < 64'(MB)) && (64'(MB) - a >= 64'd8);
`ifdef Y86_ALIGN_CHECK_EN
    r = r && (a % 8 == 0);
`endif
    return r;
  endfunction
  task automatic model_comb(output logic [3:0] st, output logic [63:0] vm, output bit dw, output logic [63:0] a);
    bit rd, wr;
    rd = mi inside {4'h5, 4'h9, 4'hB};
    wr = mi inside {4'h4, 4'h8, 4'hA};
    a = (mi == 4'h9 || mi == 4'hB) ? mva : mve;
    st = ((rd || wr) && !ok_addr(a)) ? 4'd3 : ms;
    vm = 0;
    if (rd && ok_addr(a)) for (int i = 0; i < 8; i++) vm = vm | (64'(mem[int'(a) + i]) << (8 * i));
    dw = wr && ok_addr(a) && st == 4'd1 && ws == 4'd1 && !rst;
  endtask
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic check_all();
    logic [3:0] st;
    logic [63:0] vm, a;
    bit dw;
    model_comb(st, vm, dw, a);
    check("M_stat", 64'(M_stat), 64'(ms));
    check("M_icode", 64'(M_icode), 64'(mi));
    check("M_cnd", 64'(M_cnd), 64'(mc));
    check("M_valE", M_valE, mve);
    check("M_valA", M_valA, mva);
    check("M_dstE", 64'(M_dstE), 64'(mde));
    check("M_dstM", 64'(M_dstM), 64'(mdm));
    check("m_stat", 64'(m_stat), 64'(st));
    check("m_valM", m_valM, vm);
    check("W_stat", 64'(W_stat), 64'(ws));
    check("W_icode", 64'(W_icode), 64'(wi));
    check("W_valE", W_valE, wve);
    check("W_valM", W_valM, wvm);
    check("W_dstE", 64'(W_dstE), 64'(wde));
    check("W_dstM", 64'(W_dstM), 64'(wdm));
  endtask
  task automatic cycle();
    logic [3:0] st;
    logic [63:0] vm, a;
    bit dw;
    model_comb(st, vm, dw, a);
    @(posedge clk);
    if (dw) for (int i = 0; i < 8; i++) mem[int'(a) + i] = mva[8*i +: 8];
    if (rst) {ws, wi, wve, wvm, wde, wdm} = {4'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF};
    else if (!W_stall) {ws, wi, wve, wvm, wde, wdm} = {st, mi, mve, vm, mde, mdm};
    if (rst || M_bubble) {ms, mi, mc, mve, mva, mde, mdm} = {4'd1, 4'd1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
    else {ms, mi, mc, mve, mva, mde, mdm} = {e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM};
    #1;
    check_all();
  endtask
  task automatic send(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                      input logic [3:0] st = 1, input logic [3:0] de = 15, input logic [3:0] dm = 15);
    e_icode = ic;
    e_valE = ve;
    e_valA = va;
    e_stat = st;
    e_dstE = de;
    e_dstM = dm;
    e_cnd = 1'($urandom);
    cycle();
  endtask
  initial begin
    logic [3:0] ics [12];
    ics = '{4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'h2, 4'h3, 4'h7, 4'h0};
    rst = 1;
    cycle();
    cycle();
    check("rst_M_icode", 64'(M_icode), 64'h1);
    check("rst_W_dstM", 64'(W_dstM), 64'hF);
    rst = 0;
    for (int a = 0; a < MB; a += 8) send(4'h4, 64'(a), {$urandom, $urandom});
    send(4'h4, 64'h40, 64'h1122334455667788);
    send(4'h5, 64'h40, 64'h0);
    check("wr_then_rd", m_valM, 64'h1122334455667788);
    check("model_byte40", 64'(mem[64]), 64'h88);
    check("byte40", 64'(m_valM[7:0]), 64'h88);
    send(4'h5, 64'h41, 64'h0);
`ifdef Y86_ALIGN_CHECK_EN
    check("unaligned_adr", 64'(m_stat), 64'h3);
    check("unaligned_valM", m_valM, 64'h0);
`else
    check("unaligned_rd", 64'(m_valM[55:0]), 64'h11223344556677);
`endif
    send(4'hA, 64'h1F8, 64'd7);
    send(4'hB, 64'h0, 64'h1F8);
    check("pop_valM", m_valM, 64'd7);
    send(4'h1, 64'h0, 64'h0);
    check("pop_W_valM", W_valM, 64'd7);
    send(4'h4, 64'(MB - 8), 64'h0);
    send(4'h5, 64'(MB - 7), 64'h0);
    check("adr_stat", 64'(m_stat), 64'h3);
    check("adr_valM", m_valM, 64'h0);
    send(4'h1, 64'h0, 64'h0);
    check("adr_W_stat", 64'(W_stat), 64'h3);
    send(4'h4, 64'(MB - 7), '1);
    send(4'h1, 64'h0, 64'h0);
    send(4'h5, 64'(MB - 8), 64'h0);
    check("adr_no_write", m_valM, 64'h0);
    send(4'h4, 64'h10, 64'h55);
    send(4'h1, 64'h0, 64'h0, 4'h2);
    send(4'h4, 64'h10, 64'hDEAD);
    send(4'h1, 64'h0, 64'h0);
    send(4'h5, 64'h10, 64'h0);
    check("hlt_blocks_write", m_valM, 64'h55);
    send(4'h6, 64'hAB, 64'h0, 4'h1, 4'h3);
    M_bubble = 1;
    send(4'h6, 64'hCD, 64'h0);
    M_bubble = 0;
    check("bubble_icode", 64'(M_icode), 64'h1);
    check("bubble_dstE", 64'(M_dstE), 64'hF);
    check("bubble_W_valE", W_valE, 64'hAB);
    W_stall = 1;
    send(4'h6, 64'h11, 64'h0);
    check("stall1_W_valE", W_valE, 64'hAB);
    send(4'h6, 64'h22, 64'h0);
    check("stall2_W_valE", W_valE, 64'hAB);
    check("stall2_W_dstE", 64'(W_dstE), 64'h3);
    W_stall = 0;
    send(4'h1, 64'h0, 64'h0);
    check("unstall_W_valE", W_valE, 64'h22);
    send(4'h4, 64'h80, 64'h0);
    send(4'h8, 64'h80, 64'h1234);
    rst = 1;
    send(4'h1, 64'h0, 64'h0);
    rst = 0;
    check("rst_call_M_icode", 64'(M_icode), 64'h1);
    check("rst_call_W_icode", 64'(W_icode), 64'h1);
    check("rst_call_W_valE", W_valE, 64'h0);
    send(4'h5, 64'h80, 64'h0);
    check("rst_call_no_write", m_valM, 64'h0);
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [63:0] ad;
      r = $urandom_range(0, 9);
      ad = r == 0 ? {$urandom, $urandom} : r < 3 ? 64'(MB - 16 + $urandom_range(0, 16)) : 64'($urandom_range(0, MB - 8));
      if ($urandom_range(0, 3) != 0) ad[2:0] = 3'd0;
      M_bubble = $urandom_range(0, 9) == 0;
      W_stall = $urandom_range(0, 6) == 0;
      rst = $urandom_range(0, 49) == 0;
      if ($urandom_range(0, 1) == 0)
        send(ics[$urandom_range(0, 11)], ad, {$urandom, $urandom}, $urandom_range(0, 19) == 0 ? 4'h2 : 4'h1,
             4'($urandom), 4'($urandom));
      else
        send(ics[$urandom_range(0, 11)], {$urandom, $urandom}, ad, $urandom_range(0, 19) == 0 ? 4'h4 : 4'h1,
             4'($urandom), 4'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
